// File: rtl/tm_ta_feedback_if.sv
// tm_ta_feedback_if: control, sample and TA-exclude bundle between a trainer and its driver
interface tm_ta_feedback_if #(
   parameter int NUM_FEATURES = 784
);
   logic                        start;
   logic [1:0]                  feedback_type;
   logic                        clause_output;
   logic [NUM_FEATURES-1:0]     features;
   logic [15:0]                 s_prob;
   logic                        busy;
   logic                        done;
   logic [2*NUM_FEATURES-1:0]   exclude_state;
   modport master (
      output start, feedback_type, clause_output, features, s_prob,
      input  busy, done, exclude_state
   );
   modport slave (
      input  start, feedback_type, clause_output, features, s_prob,
      output busy, done, exclude_state
   );
endinterface

// File: rtl/tm_ta_feedback.sv
// tm_ta_feedback: Tsetlin automata team trainer applying Type I/II feedback LANES literals per cycle
module tm_ta_feedback #(
   parameter int NUM_FEATURES = 784,
   parameter int STATE_BITS   = 8,
   parameter int LANES        = 8
) (
   input logic             clk,
   input logic             rst_n,
   tm_ta_feedback_if.slave bus
);
   localparam int L   = 2 * NUM_FEATURES;
   localparam int G   = (L + LANES - 1) / LANES;
   localparam int GW  = $clog2(G + 1);
   localparam int IW  = $clog2(L);
   localparam int IW1 = IW + 1;
   localparam logic [IW:0]           LV   = IW1'(L);
   localparam logic [GW-1:0]         GL   = GW'(G - 1);
   localparam logic [STATE_BITS-1:0] HALF = {1'b0, {(STATE_BITS-1){1'b1}}};
   localparam logic [STATE_BITS-1:0] SMAX = '1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

   logic [1:0]              fsm;
   logic [GW-1:0]           grp;
   logic [1:0]              fb_q;
   logic                    co_q;
   logic [NUM_FEATURES-1:0] feat_q;
   logic [15:0]             sp_q;
   logic [L-1:0]            lits;
   logic [STATE_BITS-1:0]   ta  [L];
   logic [STATE_BITS-1:0]   nxt [LANES];

   assign lits     = {~feat_q, feat_q};
   assign bus.busy = fsm == RUN;
   assign bus.done = fsm == DONE;

   always_comb
      for (int i = 0; i < L; i++) bus.exclude_state[i] = ~ta[i][STATE_BITS-1];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fsm    <= IDLE;
         grp    <= '0;
         fb_q   <= '0;
         co_q   <= 1'b0;
         feat_q <= '0;
         sp_q   <= '0;
      end else begin
         fsm <= fsm == IDLE ? (bus.start ? RUN : IDLE) : fsm == RUN ? (grp == GL ? DONE : RUN) : IDLE;
         grp <= fsm == RUN ? grp + 1'b1 : '0;
         if (fsm == IDLE && bus.start) begin
            fb_q   <= bus.feedback_type;
            co_q   <= bus.clause_output;
            feat_q <= bus.features;
            sp_q   <= bus.s_prob;
         end
      end

   // Each lane owns a private LFSR and computes the next state of the literal it visits this cycle.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [15:0]           lfsr;
      logic [IW:0]           idx;
      logic [STATE_BITS-1:0] cur;
      logic                  valid, lit, ev, inc, dec;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) lfsr <= 16'hACE1 ^ 16'(k);
         else if (fsm == RUN) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      assign idx   = IW1'(grp) * IW1'(LANES) + IW1'(k);
      assign valid = idx < LV;
      assign cur   = valid ? ta[idx[IW-1:0]] : '0;
      assign lit   = valid & lits[idx[IW-1:0]];
      assign ev    = lfsr <= sp_q;
      assign inc   = co_q && (fb_q == 2'b01 ? lit && !ev : fb_q == 2'b10 && !lit && !cur[STATE_BITS-1]);
      assign dec   = fb_q == 2'b01 && ev && !(co_q && lit);
      assign nxt[k] = inc && cur != SMAX ? cur + 1'b1 : dec && cur != '0 ? cur - 1'b1 : cur;
   end

   for (genvar i = 0; i < L; i++) begin : g_ta
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) ta[i] <= HALF;
         else if (fsm == RUN && grp == GW'(i / LANES)) ta[i] <= nxt[i % LANES];
   end
endmodule

// File: tb/tb_tm_ta_feedback.sv
// tb_tm_ta_feedback: directed and randomized passes checked against a rule-level TA team model
module tb_tm_ta_feedback;
   localparam int NF    = 784;
   localparam int L     = 2 * NF;
   localparam int LANES = 8;
   localparam int G     = (L + LANES - 1) / LANES;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   tm_ta_feedback_if #(.NUM_FEATURES(NF)) bus ();
   tm_ta_feedback #(.NUM_FEATURES(NF), .STATE_BITS(8), .LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   int checks = 0;
   int failures = 0;
   int st [L];
   logic [15:0] lf [LANES];

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < L; i++) st[i] = 127;
      for (int k = 0; k < LANES; k++) lf[k] = 16'hACE1 ^ 16'(k);
   endfunction

   function automatic void m_pass(input logic [1:0] ft, input logic co, input logic [NF-1:0] f, input logic [15:0] sp);
      for (int g = 0; g < G; g++) begin
         for (int k = 0; k < LANES; k++) begin
            int i;
            logic lit, ev;
            i = g * LANES + k;
            if (i < L) begin
               lit = i < NF ? f[i] : !f[i-NF];
               ev = lf[k] <= sp;
               if (ft == 2'b01) begin
                  if (co && lit) begin
                     if (!ev && st[i] < 255) st[i]++;
                  end else if (ev && st[i] > 0) st[i]--;
               end else if (ft == 2'b10 && co && !lit && st[i] < 128) st[i]++;
            end
         end
         for (int k = 0; k < LANES; k++) lf[k] = lfsr_next(lf[k]);
      end
   endfunction

   function automatic logic [L-1:0] exp_excl();
      logic [L-1:0] v;
      for (int i = 0; i < L; i++) v[i] = st[i] < 128;
      return v;
   endfunction

   function automatic logic [NF-1:0] rnd_feat();
      logic [NF-1:0] v;
      for (int i = 0; i < NF; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_excl(input string tag);
      logic [L-1:0] e, d;
      int first, n;
      e = exp_excl();
      d = bus.exclude_state;
      checks++;
      assert (d === e) else begin
         first = 0;
         n = 0;
         for (int i = L - 1; i >= 0; i--) if (d[i] !== e[i]) begin n++; first = i; end
         failures++;
         $error("FAIL %s exclude_state bad_bits=%0d first_bad=%0d got=%b exp=%b", tag, n, first, d[first], e[first]);
      end
   endtask

   // Inputs are scrambled right after start is taken to prove the pass uses latched copies.
   task automatic start_pass(input logic [1:0] ft, input logic co, input logic [NF-1:0] f, input logic [15:0] sp);
      @(negedge clk);
      bus.feedback_type = ft;
      bus.clause_output = co;
      bus.features = f;
      bus.s_prob = sp;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.feedback_type = 2'($urandom);
      bus.clause_output = 1'($urandom);
      bus.features = rnd_feat();
      bus.s_prob = 16'($urandom);
   endtask

   task automatic run_pass(input string tag, input logic [1:0] ft, input logic co, input logic [NF-1:0] f,
                           input logic [15:0] sp, input int poke);
      int lat, bc;
      start_pass(ft, co, f, sp);
      lat = 1;
      bc = 0;
      while (bus.done !== 1'b1 && lat < 400) begin
         if (bus.busy === 1'b1) bc++;
         bus.start = lat == poke;
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      m_pass(ft, co, f, sp);
      check({tag, "_latency"}, lat, G + 1);
      check({tag, "_busy_cycles"}, bc, G);
      check({tag, "_busy_in_done"}, 32'(bus.busy), 0);
      @(negedge clk);
      check({tag, "_done_width"}, 32'(bus.done), 0);
      check({tag, "_idle_after"}, 32'(bus.busy), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NF-1:0] ones, fives;
      int dseen;
      ones = '1;
      for (int i = 0; i < NF; i += 4) fives[i +: 4] = 4'h5;
      bus.start = 1'b0;
      bus.feedback_type = 2'b00;
      bus.clause_output = 1'b0;
      bus.features = '0;
      bus.s_prob = '0;

      // Reset state, asserted asynchronously and held
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      check_excl("reset_async");
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_done", 32'(bus.done), 0);
      repeat (5) @(negedge clk);
      check_excl("reset_hold");
      check("reset_hold_busy", 32'(bus.busy), 0);
      check("reset_hold_done", 32'(bus.done), 0);
      rst_n = 1'b1;

      // Type I reinforcement with s_prob=0, then saturation at the top
      run_pass("t1_inc", 2'b01, 1'b1, ones, 16'h0000, -1);
      check_excl("t1_inc_pass1");
      for (int p = 2; p <= 130; p++) begin
         run_pass("t1_sat", 2'b01, 1'b1, ones, 16'h0000, -1);
         if (p == 128 || p == 130) check_excl($sformatf("t1_sat_pass%0d", p));
      end

      // Type I forgetting with s_prob=FFFF down to and held at zero
      do_reset();
      for (int p = 1; p <= 129; p++) begin
         run_pass("t1_dec", 2'b01, 1'b0, rnd_feat(), 16'hFFFF, -1);
         if (p % 16 == 0 || p >= 127) check_excl($sformatf("t1_dec_pass%0d", p));
      end

      // Type II on alternating features, second pass is a no-op
      do_reset();
      run_pass("t2", 2'b10, 1'b1, fives, 16'h8000, -1);
      check_excl("t2_pass1");
      run_pass("t2b", 2'b10, 1'b1, fives, 16'h8000, -1);
      check_excl("t2_pass2");

      // Start during RUN is ignored; type 00 still walks all groups
      run_pass("poke", 2'b01, 1'b1, rnd_feat(), 16'h4000, 50);
      check_excl("poke_states");
      run_pass("none", 2'b00, 1'b1, rnd_feat(), 16'hFFFF, -1);
      check_excl("none_states");

      // Randomized passes mixing types, clause outputs and thresholds
      for (int p = 0; p < 16; p++) begin
         logic [1:0] ft;
         logic [15:0] sp;
         int sel;
         ft = 2'($urandom);
         sel = $urandom_range(0, 2);
         sp = sel == 0 ? 16'h0000 : sel == 1 ? 16'hFFFF : 16'($urandom);
         run_pass($sformatf("rnd%0d", p), ft, 1'($urandom), rnd_feat(), sp, -1);
         check_excl($sformatf("rnd%0d_states", p));
      end

      // Asynchronous abort at RUN cycle 100
      start_pass(2'b01, 1'b1, ones, 16'h0000);
      repeat (99) @(negedge clk);
      check("abort_pre_busy", 32'(bus.busy), 1);
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      check("abort_busy", 32'(bus.busy), 0);
      check_excl("abort_states");
      dseen = 0;
      for (int c = 0; c < 210; c++) begin
         @(negedge clk);
         if (c == 3) rst_n = 1'b1;
         if (bus.done === 1'b1) dseen++;
      end
      check("abort_no_done", dseen, 0);
      check_excl("abort_after");
      run_pass("post_abort", 2'b01, 1'b1, ones, 16'h0000, -1);
      check_excl("post_abort_states");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
